muldiv_seq: RTL and testbench

//  Iterative multiply/divide sequencer beside the single-cycle ALU in the execute stage. Runs one
//  33-bit add/sub per clock (radix-2 shift-add multiply, restoring divide) and owns the HI/LO

---
 rtl/mdu_pkg.sv | 30 +++
 rtl/mdu_addsub.sv | 23 ++
 rtl/muldiv_seq.sv | 215 +++++++++++++++++++++
 tb/tb_muldiv_seq.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mdu_pkg;

   localparam int MD_W     = 32;
   localparam int MD_CNT_W = $clog2(MD_W);

   // OP[0] = 1 selects the unsigned flavour, OP[1] = 1 selects divide.
   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } md_op_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_ITER = 2'd2,
      S_FIX  = 2'd3
   } md_state_t;

   function automatic logic md_is_signed(input md_op_t op);
      return ~op[0];
   endfunction

   function automatic logic md_is_div(input md_op_t op);
      return op[1];
   endfunction

endpackage

// File: rtl/mdu_addsub.sv
// W+1-bit adder/subtractor shared by the multiply and divide iterations.
// cb is bit W of the W+1-bit result: the carry for a zero-extended add,
// the borrow for a restoring-divide trial subtraction.
module mdu_addsub #(
   parameter int W = 32
) (
   input  logic [W:0]   a,
   input  logic [W:0]   b,
   input  logic         sub,
   output logic [W-1:0] sum,
   output logic         cb
);

   logic [W:0] res;

   // Two's-complement add of a and (b or ~b), with sub as carry-in.
   always_comb begin
      res = a + (sub ? ~b : b) + {{W{1'b0}}, sub};
      sum = res[W-1:0];
      cb  = res[W];
   end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer owning the HI/LO registers.
// One shift-add (multiply) or restoring trial subtract (divide) per clock.
// acc_hi/acc_lo hold {partial product, multiplier} or {remainder, quotient};
// opb holds the multiplicand or divisor. Signed ops work on magnitudes and
// fix the sign in the FIX state.
module muldiv_seq
   import mdu_pkg::*;
#(
   parameter int W     = MD_W,
   parameter int CNT_W = MD_CNT_W
) (
   input  logic         CLK,
   input  logic         RESET_N,
   input  logic         START,
   input  logic [1:0]   OP,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   input  logic         ABORT,
   input  logic         WE_HI,
   input  logic         WE_LO,
   input  logic [W-1:0] WD,
   output logic         BUSY,
   output logic         DONE,
   output logic [W-1:0] HI,
   output logic [W-1:0] LO
);

   md_state_t      state_q, state_d;
   md_op_t         op_q, op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W-1:0]   acc_hi_q, acc_hi_d;
   logic [W-1:0]   acc_lo_q, acc_lo_d;
   logic [W-1:0]   opb_q, opb_d;
   logic [W-1:0]   hi_q, hi_d;
   logic [W-1:0]   lo_q, lo_d;
   logic           neg_quo_q, neg_quo_d;
   logic           neg_rem_q, neg_rem_d;
   logic           div0_q, div0_d;
   logic           done_q, done_d;

   logic [W:0]     add_a;
   logic [W:0]     add_b;
   logic           add_sub;
   logic [W-1:0]   add_sum;
   logic           add_cb;

   logic [2*W-1:0] prod_fix;
   logic [W-1:0]   quo_fix;
   logic [W-1:0]   rem_fix;
   logic           op_signed;

   mdu_addsub #(.W(W)) u_addsub (
      .a   (add_a),
      .b   (add_b),
      .sub (add_sub),
      .sum (add_sum),
      .cb  (add_cb)
   );

   // Steer the shared adder: trial subtract for divide, conditional add for multiply.
   always_comb begin
      if (md_is_div(op_q)) begin
         add_a   = {acc_hi_q, acc_lo_q[W-1]};
         add_b   = {1'b0, opb_q};
         add_sub = 1'b1;
      end else begin
         add_a   = {1'b0, acc_hi_q};
         add_b   = acc_lo_q[0] ? {1'b0, opb_q} : '0;
         add_sub = 1'b0;
      end
   end

   // Sign-corrected results presented to HI/LO when leaving FIX.
   always_comb begin
      op_signed = md_is_signed(op_q);
      prod_fix  = {acc_hi_q, acc_lo_q};
      quo_fix   = acc_lo_q;
      rem_fix   = acc_hi_q;
      if (op_signed && neg_quo_q) begin
         prod_fix = -{acc_hi_q, acc_lo_q};
         quo_fix  = -acc_lo_q;
      end
      if (op_signed && neg_rem_q) begin
         rem_fix = -acc_hi_q;
      end
      // Divide by zero: quotient is all ones; the remainder path already
      // reproduces the dividend since nothing was ever subtracted.
      if (div0_q) begin
         quo_fix = '1;
      end
   end

   // Next-state and datapath control for IDLE -> LOAD -> ITER -> FIX.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      cnt_d     = cnt_q;
      acc_hi_d  = acc_hi_q;
      acc_lo_d  = acc_lo_q;
      opb_d     = opb_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      div0_d    = div0_q;
      done_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (WE_HI) hi_d = WD;
            if (WE_LO) lo_d = WD;
            if (START && !ABORT) begin
               state_d  = S_LOAD;
               op_d     = md_op_t'(OP);
               acc_lo_d = A;
               opb_d    = B;
            end
         end
         S_LOAD: begin
            if (ABORT) begin
               state_d = S_IDLE;
            end else begin
               // Multiply is commutative, so A always sits in acc_lo and B in
               // opb: A is multiplier or dividend, B multiplicand or divisor.
               if (md_is_signed(op_q)) begin
                  acc_lo_d  = acc_lo_q[W-1] ? -acc_lo_q : acc_lo_q;
                  opb_d     = opb_q[W-1] ? -opb_q : opb_q;
                  neg_quo_d = acc_lo_q[W-1] ^ opb_q[W-1];
                  neg_rem_d = acc_lo_q[W-1];
               end else begin
                  neg_quo_d = 1'b0;
                  neg_rem_d = 1'b0;
               end
               div0_d   = md_is_div(op_q) && (opb_q == '0);
               acc_hi_d = '0;
               cnt_d    = '0;
               state_d  = S_ITER;
            end
         end
         S_ITER: begin
            if (ABORT) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               if (md_is_div(op_q)) begin
                  // Borrow set: restore the shifted remainder and shift in 0.
                  acc_hi_d = add_cb ? add_a[W-1:0] : add_sum;
                  acc_lo_d = {acc_lo_q[W-2:0], ~add_cb};
               end else begin
                  // The carry-out becomes the new top bit of the partial product.
                  acc_hi_d = {add_cb, add_sum[W-1:1]};
                  acc_lo_d = {add_sum[0], acc_lo_q[W-1:1]};
               end
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(W - 1)) begin
                  state_d = S_FIX;
               end
            end
         end
         S_FIX: begin
            state_d = S_IDLE;
            if (!ABORT) begin
               done_d = 1'b1;
               if (md_is_div(op_q)) begin
                  hi_d = rem_fix;
                  lo_d = quo_fix;
               end else begin
                  hi_d = prod_fix[2*W-1:W];
                  lo_d = prod_fix[W-1:0];
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state_q   <= S_IDLE;
         op_q      <= MD_MULT;
         cnt_q     <= '0;
         acc_hi_q  <= '0;
         acc_lo_q  <= '0;
         opb_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         div0_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         cnt_q     <= cnt_d;
         acc_hi_q  <= acc_hi_d;
         acc_lo_q  <= acc_lo_d;
         opb_q     <= opb_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         div0_q    <= div0_d;
         done_q    <= done_d;
      end
   end

   assign BUSY = (state_q != S_IDLE);
   assign DONE = done_q;
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed vector table, hand-written
// abort/reset/strobe sequences, and random ops against an arithmetic model.
module tb_muldiv_seq;

   logic        clk = 1'b0;
   logic        RESET_N;
   logic        START;
   logic [1:0]  OP;
   logic [31:0] A;
   logic [31:0] B;
   logic        ABORT;
   logic        WE_HI;
   logic        WE_LO;
   logic [31:0] WD;
   logic        BUSY;
   logic        DONE;
   logic [31:0] HI;
   logic [31:0] LO;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t vecs[10];

   always #5 clk = ~clk;

   muldiv_seq dut (
      .CLK     (clk),
      .RESET_N (RESET_N),
      .START   (START),
      .OP      (OP),
      .A       (A),
      .B       (B),
      .ABORT   (ABORT),
      .WE_HI   (WE_HI),
      .WE_LO   (WE_LO),
      .WD      (WD),
      .BUSY    (BUSY),
      .DONE    (DONE),
      .HI      (HI),
      .LO      (LO)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference model: plain 64-bit arithmetic on the architectural rules.
   function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo);
      longint      sa;
      longint      sb;
      longint      p;
      longint      q;
      longint      r;
      logic [63:0] up;
      sa = $signed(a);
      sb = $signed(b);
      hi = '0;
      lo = '0;
      case (op)
         2'd0: begin
            p  = sa * sb;
            hi = p[63:32];
            lo = p[31:0];
         end
         2'd1: begin
            up = {32'd0, a} * {32'd0, b};
            hi = up[63:32];
            lo = up[31:0];
         end
         2'd2: begin
            if (b == 0) begin
               lo = 32'hFFFF_FFFF;
               hi = a;
            end else begin
               q  = sa / sb;
               r  = sa % sb;
               lo = q[31:0];
               hi = r[31:0];
            end
         end
         default: begin
            if (b == 0) begin
               lo = 32'hFFFF_FFFF;
               hi = a;
            end else begin
               lo = a / b;
               hi = a % b;
            end
         end
      endcase
   endfunction

   // Launch one op and wait (bounded) for DONE; reports latency and handshake health.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo,
                         output int lat, output logic hs_ok);
      @(negedge clk);
      OP    = op;
      A     = a;
      B     = b;
      START = 1'b1;
      @(posedge clk);
      @(negedge clk);
      START = 1'b0;
      hs_ok = BUSY && !DONE;
      lat   = -1;
      for (int c = 1; c <= 60; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (DONE) begin
            if (BUSY) hs_ok = 1'b0;
            lat = c;
            break;
         end
         if (!BUSY) hs_ok = 1'b0;
      end
      hi = HI;
      lo = LO;
      $display("op=%0d a=%h b=%h -> hi=%h lo=%h latency=%0d", op, a, b, hi, lo, lat);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 6))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return $urandom_range(0, 20);
         4:       return 32'h0 - $urandom_range(1, 20);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [31:0] hi;
      logic [31:0] lo;
      logic [31:0] ehi;
      logic [31:0] elo;
      int          lat;
      logic        hs_ok;
      int          dones;
      logic [1:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;

      vecs[0] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      vecs[1] = '{2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
      vecs[2] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
      vecs[3] = '{2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[4] = '{2'd3, 32'd100,       32'd7,         32'd2,         32'd14};
      vecs[5] = '{2'd3, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
      vecs[6] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
      vecs[7] = '{2'd2, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
      vecs[8] = '{2'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
      vecs[9] = '{2'd0, 32'h1234_5678, 32'd0,         32'd0,         32'd0};

      RESET_N = 1'b0;
      START   = 1'b0;
      OP      = 2'd0;
      A       = '0;
      B       = '0;
      ABORT   = 1'b0;
      WE_HI   = 1'b0;
      WE_LO   = 1'b0;
      WD      = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      RESET_N = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("reset_busy", {31'd0, BUSY}, 32'd0);
      check("reset_done", {31'd0, DONE}, 32'd0);
      check("reset_hi", HI, 32'd0);
      check("reset_lo", LO, 32'd0);

      // Directed vectors from the table.
      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, hi, lo, lat, hs_ok);
         check($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
         check($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
         check($sformatf("vec%0d_latency", i), lat, 34);
         check($sformatf("vec%0d_handshake", i), {31'd0, hs_ok}, 32'd1);
      end

      // MTLO / MTHI while idle.
      @(negedge clk);
      WE_LO = 1'b1;
      WD    = 32'h0000_1234;
      @(posedge clk);
      @(negedge clk);
      WE_LO = 1'b0;
      check("mtlo_idle", LO, 32'h0000_1234);
      WE_HI = 1'b1;
      WD    = 32'h0000_0011;
      @(posedge clk);
      @(negedge clk);
      WE_HI = 1'b0;
      WE_LO = 1'b1;
      WD    = 32'h0000_0022;
      @(posedge clk);
      @(negedge clk);
      WE_LO = 1'b0;
      check("mthi_idle", HI, 32'h0000_0011);
      check("mtlo_idle2", LO, 32'h0000_0022);

      // Strobes while busy are dropped; ABORT on iteration 10 leaves HI/LO intact.
      OP    = 2'd1;
      A     = 32'd3;
      B     = 32'd5;
      START = 1'b1;
      @(posedge clk);
      @(negedge clk);
      START = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      WE_HI = 1'b1;
      WE_LO = 1'b1;
      WD    = 32'hDEAD_BEEF;
      @(posedge clk);
      @(negedge clk);
      WE_HI = 1'b0;
      WE_LO = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      ABORT = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ABORT = 1'b0;
      check("abort_busy", {31'd0, BUSY}, 32'd0);
      dones = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (DONE) dones++;
      end
      check("abort_no_done", dones, 0);
      check("abort_hi_kept", HI, 32'h0000_0011);
      check("abort_lo_kept", LO, 32'h0000_0022);
      $display("abort sequence: hi=%h lo=%h dones=%0d", HI, LO, dones);

      // START and ABORT together in IDLE: nothing launches.
      START = 1'b1;
      ABORT = 1'b1;
      @(posedge clk);
      @(negedge clk);
      START = 1'b0;
      ABORT = 1'b0;
      check("start_abort_idle", {31'd0, BUSY}, 32'd0);

      // Second START while busy is ignored: exactly one DONE, first op's result.
      OP    = 2'd3;
      A     = 32'd100;
      B     = 32'd7;
      START = 1'b1;
      @(posedge clk);
      @(negedge clk);
      START = 1'b0;
      dones = 0;
      for (int c = 0; c < 80; c++) begin
         if (c == 10) begin
            OP    = 2'd1;
            START = 1'b1;
         end
         if (c == 11) START = 1'b0;
         @(posedge clk);
         @(negedge clk);
         if (DONE) dones++;
      end
      START = 1'b0;
      check("restart_one_done", dones, 1);
      check("restart_hi", HI, 32'd2);
      check("restart_lo", LO, 32'd14);
      $display("double start: hi=%h lo=%h dones=%0d", HI, LO, dones);

      // Random ops against the reference model.
      for (int i = 0; i < 40; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = pick();
         rb  = pick();
         model(rop, ra, rb, ehi, elo);
         run_op(rop, ra, rb, hi, lo, lat, hs_ok);
         check($sformatf("rnd%0d_hi", i), hi, ehi);
         check($sformatf("rnd%0d_lo", i), lo, elo);
         check($sformatf("rnd%0d_latency", i), lat, 34);
      end

      // Reset in the middle of ITER clears everything on the next edge.
      run_op(2'd1, 32'h0000_0100, 32'h0000_0300, hi, lo, lat, hs_ok);
      check("pre_reset_lo", lo, 32'h0003_0000);
      OP    = 2'd0;
      A     = 32'h1234_5678;
      B     = 32'h9ABC_DEF0;
      START = 1'b1;
      @(posedge clk);
      @(negedge clk);
      START = 1'b0;
      repeat (15) @(posedge clk);
      @(negedge clk);
      RESET_N = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("midreset_busy", {31'd0, BUSY}, 32'd0);
      check("midreset_done", {31'd0, DONE}, 32'd0);
      check("midreset_hi", HI, 32'd0);
      check("midreset_lo", LO, 32'd0);
      RESET_N = 1'b1;
      $display("mid-ITER reset: busy=%0d hi=%h lo=%h", BUSY, HI, LO);

      run_op(vecs[4].op, vecs[4].a, vecs[4].b, hi, lo, lat, hs_ok);
      check("post_reset_hi", hi, vecs[4].hi);
      check("post_reset_lo", lo, vecs[4].lo);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
